life_gen_ctrl: RTL

Generation sequencer for the 40×25 cellular-automaton grid. It snapshots the current grid, scans every cell through one shared neighbour-count/rule engine, and builds the next-generation vector. It then issues a one-cycle commit pulse so the downstream grid register captures the result. It sits between the run/step user controls and the grid copy/storage stage, whose output feeds back into `cur`.

---
 rtl/life_pkg.sv | 26 ++
 rtl/life_cell_rule.sv | 31 +++
 rtl/life_gen_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared constants and types for the generation sequencer.
//   GRID_N / GRID_M    : default grid columns / rows
//   COL_W / ROW_W      : counter widths for the default grid
//   CNT_W / GEN_W      : neighbour-count and generation-counter widths
//   gen_state_t        : sequencer states
//   BIRTH, SURVIVE_*   : B3/S23 rule thresholds
package life_pkg;

    localparam int unsigned GRID_N = 40;
    localparam int unsigned GRID_M = 25;
    localparam int unsigned COL_W  = $clog2(GRID_N);
    localparam int unsigned ROW_W  = $clog2(GRID_M);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned GEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } gen_state_t;

    localparam logic [CNT_W-1:0] BIRTH      = 4'd3;
    localparam logic [CNT_W-1:0] SURVIVE_LO = 4'd2;
    localparam logic [CNT_W-1:0] SURVIVE_HI = 4'd3;

endpackage

// File: rtl/life_cell_rule.sv
// Combinational B3/S23 rule for one cell.
//   cells   : [8] = the cell itself, [7:0] = its eight neighbours
//   alive_c : next-generation state of the cell
//   count_c : number of live neighbours (0..8)
module life_cell_rule
    import life_pkg::*;
(
    input  logic [8:0]       cells,
    output logic             alive_c,
    output logic [CNT_W-1:0] count_c
);

    // Population count of the neighbour bits.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < 8; i++) begin
            count_c = count_c + CNT_W'(cells[i]);
        end
    end

    // Live cell survives on 2 or 3 neighbours; dead cell is born on exactly 3.
    always_comb begin
        alive_c = 1'b0;
        if (cells[8]) begin
            alive_c = (count_c >= SURVIVE_LO) && (count_c <= SURVIVE_HI);
        end else begin
            alive_c = (count_c == BIRTH);
        end
    end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: snapshots the grid, scans one cell per cycle through a
// shared rule engine, then pulses commit.
//   clk, rst        : clock, synchronous active-high reset
//   run, tick, step : start controls (step, or run&tick, while idle)
//   cur             : current grid, bit index r*N + c
//   next            : next-generation grid, built one bit per scan cycle
//   commit          : one-cycle pulse, next is complete
//   busy            : high from first scan cycle through the commit cycle
//   gen_count       : generations committed since reset (wraps)
module life_gen_ctrl
    import life_pkg::*;
#(
    parameter int unsigned N = GRID_N,
    parameter int unsigned M = GRID_M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             tick,
    input  logic             step,
    input  logic [N*M-1:0]   cur,
    output logic [N*M-1:0]   next,
    output logic             commit,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    localparam int unsigned CELLS = N * M;
    localparam int unsigned C_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned R_W   = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned I_W   = (CELLS > 1) ? $clog2(CELLS) : 1;

    gen_state_t     state;
    gen_state_t     state_nx;
    logic [R_W-1:0] row;
    logic [C_W-1:0] col;
    logic [CELLS-1:0] snap;

    logic           start_c;
    logic           col_last_c;
    logic           last_cell_c;
    logic [R_W-1:0] row_up_c;
    logic [R_W-1:0] row_dn_c;
    logic [C_W-1:0] col_lf_c;
    logic [C_W-1:0] col_rt_c;
    logic [8:0]     cells_c;
    logic           alive_c;
    // Neighbour count is only needed inside the rule; kept for probing.
    logic [CNT_W-1:0] count_unused;

    function automatic logic [I_W-1:0] cell_idx(input logic [R_W-1:0] rr,
                                                input logic [C_W-1:0] cc);
        return I_W'(rr) * I_W'(N) + I_W'(cc);
    endfunction

    assign start_c     = step | (run & tick);
    assign col_last_c  = (col == C_W'(N - 1));
    assign last_cell_c = col_last_c && (row == R_W'(M - 1));

    // Toroidal neighbour coordinates.
    always_comb begin
        row_up_c = (row == '0)          ? R_W'(M - 1) : row - R_W'(1);
        row_dn_c = (row == R_W'(M - 1)) ? '0          : row + R_W'(1);
        col_lf_c = (col == '0)          ? C_W'(N - 1) : col - C_W'(1);
        col_rt_c = col_last_c           ? '0          : col + C_W'(1);
    end

    // Gather self plus the eight neighbours out of the snapshot.
    always_comb begin
        cells_c    = '0;
        cells_c[8] = snap[cell_idx(row,      col)];
        cells_c[7] = snap[cell_idx(row_up_c, col_lf_c)];
        cells_c[6] = snap[cell_idx(row_up_c, col)];
        cells_c[5] = snap[cell_idx(row_up_c, col_rt_c)];
        cells_c[4] = snap[cell_idx(row,      col_lf_c)];
        cells_c[3] = snap[cell_idx(row,      col_rt_c)];
        cells_c[2] = snap[cell_idx(row_dn_c, col_lf_c)];
        cells_c[1] = snap[cell_idx(row_dn_c, col)];
        cells_c[0] = snap[cell_idx(row_dn_c, col_rt_c)];
    end

    life_cell_rule u_rule (
        .cells   (cells_c),
        .alive_c (alive_c),
        .count_c (count_unused)
    );

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_c)     state_nx = SCAN;
            SCAN:    if (last_cell_c) state_nx = COMMIT;
            COMMIT:                   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // State, counters, snapshot, result vector and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            snap      <= '0;
            next      <= '0;
            commit    <= 1'b0;
            busy      <= 1'b0;
            gen_count <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != IDLE);
            commit <= (state_nx == COMMIT);
            case (state)
                IDLE: begin
                    if (start_c) begin
                        snap <= cur;
                        row  <= '0;
                        col  <= '0;
                    end
                end
                SCAN: begin
                    next[cell_idx(row, col)] <= alive_c;
                    if (col_last_c) begin
                        col <= '0;
                        row <= row + R_W'(1);
                    end else begin
                        col <= col + C_W'(1);
                    end
                end
                COMMIT: begin
                    gen_count <= gen_count + GEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
